// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset datapath: sequences fetch/decode/execute/
// memory/write-back and drives datapath enables, mux selects and the ALUOp/Funct_Code pair.
module multicycle_control #(
  parameter int unsigned RETIRED_W = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [31:0]          Instr,
  input  logic                 Mem_Ready,
  output logic [1:0]           Operation,
  output logic [6:0]           Funct_Code,
  output logic                 ALU_Src_A,
  output logic [1:0]           ALU_Src_B,
  output logic                 PC_Source,
  output logic                 PC_Write,
  output logic                 PC_Write_Cond,
  output logic                 IR_Write,
  output logic                 Mem_Read,
  output logic                 Mem_Write,
  output logic                 I_or_D,
  output logic                 Reg_Write,
  output logic                 Mem_to_Reg,
  output logic                 Illegal,
  output logic [RETIRED_W-1:0] Retired
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBranch, StTrap
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e                r_state;
  state_e                w_next;
  logic [6:0]            r_funct;
  logic [6:0]            w_funct;
  logic                  r_is_store;
  logic                  w_retire;
  logic [RETIRED_W-1:0]  r_retired;
  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic                  w_unused_instr;

  assign w_opcode       = Instr[6:0];
  assign w_f3           = Instr[14:12];
  assign w_unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // Only R-type distinguishes add/sub via Instr[30]; I-type uses it as immediate bits.
  always_comb begin
    w_funct = 7'b0000000;
    case (w_f3)
      3'b000:  w_funct = (Instr[30] && (w_opcode == OpR)) ? 7'b1000001 : 7'b1000000;
      3'b111:  w_funct = 7'b1000100;
      3'b110:  w_funct = 7'b1000101;
      3'b100:  w_funct = 7'b1000110;
      3'b010:  w_funct = 7'b1010100;
      default: w_funct = 7'b0000000;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      StFetch:    if (Mem_Ready) w_next = StDecode;
      StDecode: begin
        case (w_opcode)
          OpR:             w_next = StExecR;
          OpI:             w_next = StExecI;
          OpLoad, OpStore: w_next = StMemAddr;
          OpBranch:        w_next = StBranch;
          default:         w_next = StTrap;
        endcase
      end
      StMemAddr:  w_next = r_is_store ? StMemWrite : StMemRead;
      StMemRead:  if (Mem_Ready) w_next = StMemWb;
      StMemWb: begin
        w_next   = StFetch;
        w_retire = 1'b1;
      end
      StMemWrite: begin
        if (Mem_Ready) begin
          w_next   = StFetch;
          w_retire = 1'b1;
        end
      end
      StExecR, StExecI: w_next = StAluWb;
      StAluWb, StBranch: begin
        w_next   = StFetch;
        w_retire = 1'b1;
      end
      StTrap:     w_next = StTrap;
      default:    w_next = StFetch;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= StFetch;
      r_funct    <= 7'b0000000;
      r_is_store <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      // Instr is only trusted in DECODE; the store/load choice is carried forward.
      if (r_state == StDecode) begin
        r_funct    <= w_funct;
        r_is_store <= Instr[5];
      end
      if (w_retire) r_retired <= r_retired + RETIRED_W'(1);
    end
  end

  always_comb begin
    Operation     = 2'b00;
    ALU_Src_A     = 1'b0;
    ALU_Src_B     = 2'b00;
    PC_Source     = 1'b0;
    PC_Write      = 1'b0;
    PC_Write_Cond = 1'b0;
    IR_Write      = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    I_or_D        = 1'b0;
    Reg_Write     = 1'b0;
    Mem_to_Reg    = 1'b0;
    unique case (r_state)
      StFetch: begin
        Mem_Read  = 1'b1;
        ALU_Src_B = 2'b01;
        IR_Write  = Mem_Ready;
        PC_Write  = Mem_Ready;
      end
      StDecode:   ALU_Src_B = 2'b10;
      StMemAddr: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
      end
      StMemRead: begin
        I_or_D   = 1'b1;
        Mem_Read = 1'b1;
      end
      StMemWb: begin
        Reg_Write  = 1'b1;
        Mem_to_Reg = 1'b1;
      end
      StMemWrite: begin
        I_or_D    = 1'b1;
        Mem_Write = 1'b1;
      end
      StExecR: begin
        ALU_Src_A = 1'b1;
        Operation = 2'b10;
      end
      StExecI: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        Operation = 2'b10;
      end
      StAluWb:    Reg_Write = 1'b1;
      StBranch: begin
        ALU_Src_A     = 1'b1;
        Operation     = 2'b01;
        PC_Write_Cond = 1'b1;
        PC_Source     = 1'b1;
      end
      StTrap:     ;
      default:    ;
    endcase
    // Reset suppresses every write and parks the selects on their FETCH values.
    if (!Reset) begin
      Operation     = 2'b00;
      ALU_Src_A     = 1'b0;
      ALU_Src_B     = 2'b01;
      PC_Source     = 1'b0;
      PC_Write      = 1'b0;
      PC_Write_Cond = 1'b0;
      IR_Write      = 1'b0;
      Mem_Read      = 1'b0;
      Mem_Write     = 1'b0;
      I_or_D        = 1'b0;
      Reg_Write     = 1'b0;
      Mem_to_Reg    = 1'b0;
    end
  end

  assign Funct_Code = r_funct;
  assign Illegal    = (r_state == StTrap);
  assign Retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle and
// compares the packed control vector, Funct_Code, Illegal and Retired to hand-derived values.
module tb_multicycle_control;

  logic        Clock;
  logic        Reset;
  logic [31:0] Instr;
  logic        Mem_Ready;
  logic [1:0]  Operation;
  logic [6:0]  Funct_Code;
  logic        ALU_Src_A;
  logic [1:0]  ALU_Src_B;
  logic        PC_Source, PC_Write, PC_Write_Cond, IR_Write, Mem_Read, Mem_Write;
  logic        I_or_D, Reg_Write, Mem_to_Reg, Illegal;
  logic [15:0] Retired;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_retired = 16'd0;

  multicycle_control #(.RETIRED_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Instr(Instr), .Mem_Ready(Mem_Ready),
    .Operation(Operation), .Funct_Code(Funct_Code), .ALU_Src_A(ALU_Src_A),
    .ALU_Src_B(ALU_Src_B), .PC_Source(PC_Source), .PC_Write(PC_Write),
    .PC_Write_Cond(PC_Write_Cond), .IR_Write(IR_Write), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .I_or_D(I_or_D), .Reg_Write(Reg_Write),
    .Mem_to_Reg(Mem_to_Reg), .Illegal(Illegal), .Retired(Retired)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {Op, SrcA, SrcB, PCSrc, PCW, PCWC, IRW, MemRd, MemWr, IorD, RegWr, MemToReg}
  logic [13:0] w_ctrl;
  assign w_ctrl = {Operation, ALU_Src_A, ALU_Src_B, PC_Source, PC_Write, PC_Write_Cond,
                   IR_Write, Mem_Read, Mem_Write, I_or_D, Reg_Write, Mem_to_Reg};

  localparam logic [13:0] C_FETCH   = {2'b00, 1'b0, 2'b01, 1'b0, 8'b1011_0000};
  localparam logic [13:0] C_FETCH_W = {2'b00, 1'b0, 2'b01, 1'b0, 8'b0001_0000};
  localparam logic [13:0] C_DECODE  = {2'b00, 1'b0, 2'b10, 1'b0, 8'b0000_0000};
  localparam logic [13:0] C_MADDR   = {2'b00, 1'b1, 2'b10, 1'b0, 8'b0000_0000};
  localparam logic [13:0] C_MREAD   = {2'b00, 1'b0, 2'b00, 1'b0, 8'b0001_0100};
  localparam logic [13:0] C_MWB     = {2'b00, 1'b0, 2'b00, 1'b0, 8'b0000_0011};
  localparam logic [13:0] C_MWRITE  = {2'b00, 1'b0, 2'b00, 1'b0, 8'b0000_1100};
  localparam logic [13:0] C_EXEC_R  = {2'b10, 1'b1, 2'b00, 1'b0, 8'b0000_0000};
  localparam logic [13:0] C_EXEC_I  = {2'b10, 1'b1, 2'b10, 1'b0, 8'b0000_0000};
  localparam logic [13:0] C_ALU_WB  = {2'b00, 1'b0, 2'b00, 1'b0, 8'b0000_0010};
  localparam logic [13:0] C_BRANCH  = {2'b01, 1'b1, 2'b00, 1'b1, 8'b0100_0000};
  localparam logic [13:0] C_TRAP    = 14'b0;
  localparam logic [13:0] C_RST     = {2'b00, 1'b0, 2'b01, 1'b0, 8'b0000_0000};

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Mem_Ready = 1'b1;
    Instr = 32'h0;
    repeat (3) begin
      step();
      n_cmp++;
      if (w_ctrl !== C_RST) begin
        n_err++;
        $display("FAIL reset_ctrl got %b want %b", w_ctrl, C_RST);
      end
    end
    n_cmp++;
    if (Retired !== 16'd0 || Illegal !== 1'b0 || Funct_Code !== 7'd0) begin
      n_err++;
      $display("FAIL reset_regs got ret=%0d ill=%b fc=%b want 0/0/0", Retired, Illegal,
               Funct_Code);
    end
    Reset = 1'b1;
    Mem_Ready = 1'b0;
    #1;
    n_cmp++;
    if (w_ctrl !== C_FETCH_W) begin
      n_err++;
      $display("FAIL reset_first_fetch got %b want %b", w_ctrl, C_FETCH_W);
    end
    step();
    n_cmp++;
    if (w_ctrl !== C_FETCH_W) begin
      n_err++;
      $display("FAIL fetch_wait_hold got %b want %b", w_ctrl, C_FETCH_W);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ins [2] = '{32'h40208033, {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011}};
    logic [6:0]  fc  [2] = '{7'b1000001, 7'b1000100};
    logic [13:0] ec  [4] = '{C_FETCH, C_DECODE, C_EXEC_R, C_ALU_WB};
    for (int k = 0; k < 2; k++) begin
      Instr = ins[k];
      for (int i = 0; i < 4; i++) begin
        Mem_Ready = (i == 0) ? 1'b1 : 1'b0;
        #1;
        n_cmp++;
        if (w_ctrl !== ec[i]) begin
          n_err++;
          $display("FAIL rtype%0d cyc%0d got %b want %b", k, i, w_ctrl, ec[i]);
        end
        step();
      end
      exp_retired++;
      n_cmp++;
      if (Funct_Code !== fc[k] || Retired !== exp_retired) begin
        n_err++;
        $display("FAIL rtype%0d_end got fc=%b ret=%0d want fc=%b ret=%0d", k, Funct_Code,
                 Retired, fc[k], exp_retired);
      end
    end
  endtask

  task automatic test_itype();
    // xori with bit30 set, slti, ori, addi with bit30 set, slli (unmapped f3)
    logic [31:0] ins [5] = '{{7'b0100000, 5'd3, 5'd1, 3'b100, 5'd4, 7'b0010011},
                             {7'b0000000, 5'd3, 5'd1, 3'b010, 5'd4, 7'b0010011},
                             {7'b0000000, 5'd3, 5'd1, 3'b110, 5'd4, 7'b0010011},
                             {7'b0100000, 5'd3, 5'd1, 3'b000, 5'd4, 7'b0010011},
                             {7'b0000000, 5'd3, 5'd1, 3'b001, 5'd4, 7'b0010011}};
    logic [6:0]  fc  [5] = '{7'b1000110, 7'b1010100, 7'b1000101, 7'b1000000, 7'b0000000};
    logic [13:0] ec  [4] = '{C_FETCH, C_DECODE, C_EXEC_I, C_ALU_WB};
    for (int k = 0; k < 5; k++) begin
      Instr = ins[k];
      for (int i = 0; i < 4; i++) begin
        Mem_Ready = 1'b1;
        #1;
        n_cmp++;
        if (w_ctrl !== ec[i]) begin
          n_err++;
          $display("FAIL itype%0d cyc%0d got %b want %b", k, i, w_ctrl, ec[i]);
        end
        step();
      end
      exp_retired++;
      n_cmp++;
      if (Funct_Code !== fc[k] || Retired !== exp_retired) begin
        n_err++;
        $display("FAIL itype%0d_end got fc=%b ret=%0d want fc=%b ret=%0d", k, Funct_Code,
                 Retired, fc[k], exp_retired);
      end
    end
  endtask

  task automatic test_load();
    logic [13:0] ec [7] = '{C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MWB};
    logic        rd [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      // After DECODE the instruction bus shows a store; the load path must not change.
      Instr = (i < 2) ? {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011} : 32'h0020A423;
      Mem_Ready = rd[i];
      #1;
      n_cmp++;
      if (w_ctrl !== ec[i]) begin
        n_err++;
        $display("FAIL load cyc%0d got %b want %b", i, w_ctrl, ec[i]);
      end
      step();
    end
    exp_retired++;
    n_cmp++;
    if (Funct_Code !== 7'b1010100 || Retired !== exp_retired) begin
      n_err++;
      $display("FAIL load_end got fc=%b ret=%0d want fc=1010100 ret=%0d", Funct_Code,
               Retired, exp_retired);
    end
  endtask

  task automatic test_store_branch();
    logic [13:0] es [5] = '{C_FETCH, C_DECODE, C_MADDR, C_MWRITE, C_MWRITE};
    logic        rs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [13:0] eb [3] = '{C_FETCH, C_DECODE, C_BRANCH};
    Instr = 32'h0020A423;
    for (int i = 0; i < 5; i++) begin
      Mem_Ready = rs[i];
      #1;
      n_cmp++;
      if (w_ctrl !== es[i]) begin
        n_err++;
        $display("FAIL store cyc%0d got %b want %b", i, w_ctrl, es[i]);
      end
      step();
    end
    exp_retired++;
    Instr = 32'h00208463;
    for (int i = 0; i < 3; i++) begin
      Mem_Ready = 1'b1;
      #1;
      n_cmp++;
      if (w_ctrl !== eb[i]) begin
        n_err++;
        $display("FAIL branch cyc%0d got %b want %b", i, w_ctrl, eb[i]);
      end
      step();
    end
    exp_retired++;
    n_cmp++;
    if (Funct_Code !== 7'b1000000 || Retired !== exp_retired) begin
      n_err++;
      $display("FAIL branch_end got fc=%b ret=%0d want fc=1000000 ret=%0d", Funct_Code,
               Retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid();
    Instr = {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011};
    Mem_Ready = 1'b1;
    repeat (3) step();
    Mem_Ready = 1'b0;
    #1;
    n_cmp++;
    if (w_ctrl !== C_MREAD) begin
      n_err++;
      $display("FAIL mid_pre got %b want %b", w_ctrl, C_MREAD);
    end
    Reset = 1'b0;
    Mem_Ready = 1'b1;
    #1;
    n_cmp++;
    if (w_ctrl !== C_RST) begin
      n_err++;
      $display("FAIL mid_reset_ctrl got %b want %b", w_ctrl, C_RST);
    end
    step();
    Reset = 1'b1;
    #1;
    exp_retired = 16'd0;
    n_cmp++;
    if (w_ctrl !== C_FETCH || Retired !== 16'd0 || Funct_Code !== 7'd0) begin
      n_err++;
      $display("FAIL mid_after got ctrl=%b ret=%0d fc=%b want ctrl=%b ret=0 fc=0", w_ctrl,
               Retired, Funct_Code, C_FETCH);
    end
  endtask

  task automatic test_trap();
    Instr = 32'h0000007F;
    Mem_Ready = 1'b1;
    step();
    #1;
    n_cmp++;
    if (w_ctrl !== C_DECODE || Illegal !== 1'b0) begin
      n_err++;
      $display("FAIL trap_decode got ctrl=%b ill=%b want ctrl=%b ill=0", w_ctrl, Illegal,
               C_DECODE);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      Mem_Ready = i[0];
      Instr = 32'h00000033;
      #1;
      n_cmp++;
      if (w_ctrl !== C_TRAP || Illegal !== 1'b1 || Retired !== exp_retired) begin
        n_err++;
        $display("FAIL trap cyc%0d got ctrl=%b ill=%b ret=%0d want ctrl=%b ill=1 ret=%0d", i,
                 w_ctrl, Illegal, Retired, C_TRAP, exp_retired);
      end
      step();
    end
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    Mem_Ready = 1'b1;
    #1;
    n_cmp++;
    if (w_ctrl !== C_FETCH || Illegal !== 1'b0) begin
      n_err++;
      $display("FAIL trap_clear got ctrl=%b ill=%b want ctrl=%b ill=0", w_ctrl, Illegal,
               C_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_store_branch();
    test_reset_mid();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
